tens_comp_bcd_alu: RTL and testbench

Sequential three-digit BCD adder/subtractor using ten's-complement arithmetic, one decimal digit per clock. It formats the signed result as four display digit codes for the 4-digit seven-segment display driver, which consumes `disp[15:0]` directly, one nibble per digit with digit 3 leftmost. It also handles sign, overflow into a fourth digit, leading-zero blanking and invalid-BCD error display.

---
 rtl/tens_comp_bcd_alu.sv | 159 +++++++++++++++
 tb/tb_tens_comp_bcd_alu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tens_comp_bcd_alu.sv
// Three-digit BCD adder/subtractor, one digit per clock, using ten's-complement
// subtraction with recomplement of negative results; drives four display digit codes.
module tens_comp_bcd_alu #(
  parameter logic [3:0] BLANK = 4'hB,
  parameter logic [3:0] DASH  = 4'hA
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        op,
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [15:0] disp,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, NEG = 2'd2, FMT = 2'd3} state_t;

  state_t      state_r;
  logic [11:0] a_r;
  logic [11:0] b_r;
  logic [11:0] res_r;
  logic [1:0]  idx_r;
  logic        op_r;
  logic        carry_r;
  logic        cf_r;
  logic        neg_r;

  logic [3:0]  a_dig_s;
  logic [3:0]  b_dig_s;
  logic [3:0]  r_dig_s;
  logic [4:0]  add_out_s;
  logic [4:0]  neg_out_s;

  function automatic logic bcd_ok(input logic [11:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

  // Returns {carry, digit} of x + y + c with decimal adjust.
  function automatic logic [4:0] dec_add(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] s;
    logic [4:0] t;
    s = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    t = s - 5'd10;
    if (s > 5'd9) return {1'b1, t[3:0]};
    else          return {1'b0, s[3:0]};
  endfunction

  function automatic logic [15:0] format_disp(input logic e, input logic o, input logic f,
                                              input logic n, input logic [11:0] r);
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    if (e) return {DASH, DASH, DASH, DASH};
    else begin
      if (!o && f)  d3 = 4'h1;
      else if (n)   d3 = DASH;
      else          d3 = BLANK;
      // A leading 1 means a four-digit value, so inner zeros are significant.
      if (d3 != 4'h1 && r[11:8] == 4'h0) begin
        d2 = BLANK;
        d1 = (r[7:4] == 4'h0) ? BLANK : r[7:4];
      end else begin
        d2 = r[11:8];
        d1 = r[7:4];
      end
      return {d3, d2, d1, r[3:0]};
    end
  endfunction

  // Digit selection and the per-digit add / recomplement step.
  always_comb begin
    a_dig_s   = a_r[{idx_r, 2'b00} +: 4];
    b_dig_s   = b_r[{idx_r, 2'b00} +: 4];
    r_dig_s   = res_r[{idx_r, 2'b00} +: 4];
    add_out_s = dec_add(a_dig_s, op_r ? (4'd9 - b_dig_s) : b_dig_s, carry_r);
    neg_out_s = dec_add(4'd9 - r_dig_s, 4'd0, carry_r);
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= IDLE;
      a_r     <= 12'h000;
      b_r     <= 12'h000;
      res_r   <= 12'h000;
      idx_r   <= 2'd0;
      op_r    <= 1'b0;
      carry_r <= 1'b0;
      cf_r    <= 1'b0;
      neg_r   <= 1'b0;
      disp    <= {BLANK, BLANK, BLANK, 4'h0};
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op;
            idx_r   <= 2'd0;
            carry_r <= op;
            cf_r    <= 1'b0;
            neg_r   <= 1'b0;
            busy    <= 1'b1;
            if (!bcd_ok(a) || !bcd_ok(b)) begin
              err     <= 1'b1;
              state_r <= FMT;
            end else begin
              err     <= 1'b0;
              state_r <= ADD;
            end
          end
        end
        ADD: begin
          res_r[{idx_r, 2'b00} +: 4] <= add_out_s[3:0];
          carry_r                    <= add_out_s[4];
          if (idx_r == 2'd2) begin
            idx_r <= 2'd0;
            // No carry out of a subtraction means the result is negative.
            if (op_r && !add_out_s[4]) begin
              carry_r <= 1'b1;
              state_r <= NEG;
            end else begin
              cf_r    <= add_out_s[4];
              state_r <= FMT;
            end
          end else begin
            idx_r <= idx_r + 2'd1;
          end
        end
        NEG: begin
          res_r[{idx_r, 2'b00} +: 4] <= neg_out_s[3:0];
          carry_r                    <= neg_out_s[4];
          if (idx_r == 2'd2) begin
            idx_r   <= 2'd0;
            neg_r   <= 1'b1;
            state_r <= FMT;
          end else begin
            idx_r <= idx_r + 2'd1;
          end
        end
        FMT: begin
          disp    <= format_disp(err, op_r, cf_r, neg_r, res_r);
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tens_comp_bcd_alu.sv
// Directed and random checks of tens_comp_bcd_alu against an integer-arithmetic
// model of the displayed result, latency and error flag.
module tb_tens_comp_bcd_alu;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [11:0] a = 12'h000;
  logic [11:0] b = 12'h000;
  logic [15:0] disp;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  tens_comp_bcd_alu #(.BLANK(4'hB), .DASH(4'hA)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .disp(disp), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the decimal values.
  task automatic model(input logic o, input logic [11:0] x, input logic [11:0] y,
                       output logic [15:0] ed, output logic ee, output int el);
    bit bad;
    int va, vb, r, m, h, t, u, d3;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (((x >> (4 * k)) & 12'hF) > 9) bad = 1;
      if (((y >> (4 * k)) & 12'hF) > 9) bad = 1;
    end
    if (bad) begin
      ed = 16'hAAAA; ee = 1'b1; el = 1;
    end else begin
      va = 100 * int'(x[11:8]) + 10 * int'(x[7:4]) + int'(x[3:0]);
      vb = 100 * int'(y[11:8]) + 10 * int'(y[7:4]) + int'(y[3:0]);
      r  = o ? va - vb : va + vb;
      ee = 1'b0;
      if (r < 0)          begin d3 = 10; m = -r;       el = 7; end
      else if (r >= 1000) begin d3 = 1;  m = r - 1000; el = 4; end
      else                begin d3 = 11; m = r;        el = 4; end
      h = m / 100; t = (m / 10) % 10; u = m % 10;
      if (d3 != 1 && h == 0) begin
        h = 11;
        if (t == 0) t = 11;
      end
      ed = {d3[3:0], h[3:0], t[3:0], u[3:0]};
    end
  endtask

  // Drive start at the current negedge; returns at the negedge after acceptance.
  task automatic start_op(input logic o, input logic [11:0] x, input logic [11:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 12'($urandom); b = 12'($urandom); op = 1'($urandom);
    check("busy_after_accept", {15'd0, busy}, 16'd1);
    check("done_low_after_accept", {15'd0, done}, 16'd0);
  endtask

  // Wait for done and compare everything; returns in the done cycle.
  task automatic wait_done(input logic o, input logic [11:0] x, input logic [11:0] y,
                           input bit noise);
    logic [15:0] ed;
    logic        ee;
    int          el, n, busy_cycles;
    model(o, x, y, ed, ee, el);
    n = 0;
    busy_cycles = 0;
    while (!done && n < 20) begin
      busy_cycles += int'(busy);
      if (noise) begin
        start = 1'($urandom); op = 1'($urandom);
        a = 12'($urandom); b = 12'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check($sformatf("latency_%h_%h_op%0d", x, y, o), 16'(n), 16'(el));
    check($sformatf("disp_%h_%h_op%0d", x, y, o), disp, ed);
    check("err", {15'd0, err}, {15'd0, ee});
    check("busy_at_done", {15'd0, busy}, 16'd0);
    check("busy_cycles", 16'(busy_cycles), 16'(el));
  endtask

  task automatic run_op(input logic o, input logic [11:0] x, input logic [11:0] y, input bit noise);
    start_op(o, x, y);
    wait_done(o, x, y, noise);
    @(negedge clk);
    check("done_one_cycle", {15'd0, done}, 16'd0);
  endtask

  function automatic logic [11:0] rand_operand();
    logic [11:0] v;
    for (int k = 0; k < 3; k++) begin
      if ($urandom_range(0, 19) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else                            v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic reset_check(input string tag);
    #1;
    check({tag, "_disp"}, disp, 16'hBBB0);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_done"}, {15'd0, done}, 16'd0);
    check({tag, "_err"}, {15'd0, err}, 16'd0);
  endtask

  task automatic no_done_window(input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(tag, 16'(seen), 16'd0);
  endtask

  initial begin
    logic        ro;
    logic [11:0] rx, ry;

    repeat (3) @(negedge clk);
    reset_check("reset");
    clr = 1'b1;
    @(negedge clk);

    run_op(1'b0, 12'h123, 12'h456, 0);
    run_op(1'b0, 12'h999, 12'h999, 0);
    run_op(1'b0, 12'h000, 12'h007, 0);
    run_op(1'b0, 12'h050, 12'h050, 0);
    run_op(1'b1, 12'h500, 12'h500, 0);
    run_op(1'b1, 12'h005, 12'h012, 0);
    run_op(1'b1, 12'h000, 12'h999, 0);
    run_op(1'b0, 12'h0A0, 12'h001, 0);
    run_op(1'b0, 12'h001, 12'h002, 0);

    // Start pulses while busy must be ignored.
    run_op(1'b1, 12'h010, 12'h987, 1);
    run_op(1'b0, 12'h456, 12'h789, 1);

    // Back-to-back: next start issued in the done cycle.
    start_op(1'b0, 12'h321, 12'h111);
    wait_done(1'b0, 12'h321, 12'h111, 0);
    start_op(1'b1, 12'h100, 12'h200);
    wait_done(1'b1, 12'h100, 12'h200, 0);
    start_op(1'b0, 12'hF00, 12'h000);
    wait_done(1'b0, 12'hF00, 12'h000, 0);
    start_op(1'b1, 12'h750, 12'h250);
    wait_done(1'b1, 12'h750, 12'h250, 0);
    @(negedge clk);

    // Reset mid-ADD.
    start_op(1'b1, 12'h005, 12'h012);
    @(negedge clk);
    clr = 1'b0;
    reset_check("clr_mid_add");
    @(negedge clk);
    clr = 1'b1;
    no_done_window("no_done_after_clr_add");

    // Reset mid-NEG.
    start_op(1'b1, 12'h005, 12'h012);
    repeat (4) @(negedge clk);
    clr = 1'b0;
    reset_check("clr_mid_neg");
    @(negedge clk);
    clr = 1'b1;
    no_done_window("no_done_after_clr_neg");
    run_op(1'b1, 12'h005, 12'h012, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      rx = rand_operand();
      ry = rand_operand();
      run_op(ro, rx, ry, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
